gcd_job_arbiter: RTL and testbench

- Shares one subtract-loop GCD engine (A/B registers, subtractor, comparator, FSM) between N_REQ requesters.
- Round-robin selects one job at a time and captures its operands.
- Sequences the engine's serial load protocol: start, then A, then B on one shared data bus; waits for done, then returns the result to the owning requester.
- Bypasses the engine for zero operands, because the subtract loop never terminates on a zero.

---
 rtl/gcd_pkg.sv | 21 ++
 rtl/gcd_job_arbiter_rr_picker.sv | 31 +++
 rtl/gcd_job_arbiter.sv | 209 ++++++++++++++++++++
 tb/tb_gcd_job_arbiter.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/gcd_pkg.sv
// Shared definitions for the GCD job arbiter: FSM state encoding and
// default sizing. Optional build macro used by the top: GCD_TIMEOUT_EN.
package gcd_pkg;

  // Arbiter FSM states (3-bit encoding).
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD_A = 3'd1,
    LOAD_B = 3'd2,
    WAIT   = 3'd3,
    RESP   = 3'd4,
    CLEAR  = 3'd5
  } gcd_state_e;

  // Default operand/result width.
  localparam int GCD_W_DEF       = 16;

  // Default watchdog limit, in WAIT cycles.
  localparam int GCD_TIMEOUT_DEF = 1024;

endpackage

// File: rtl/gcd_job_arbiter_rr_picker.sv
// rr_picker: combinational round-robin priority select. Searches upward
// from rr_ptr+1, wrapping modulo N_REQ, and returns the first requester
// with its bit set. Intended for reuse by other shared-resource arbiters.
module rr_picker #(
  parameter int N_REQ = 4,
  parameter int IW    = 2
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IW-1:0]    rr_ptr,
  output logic [IW-1:0]    grant,
  output logic             any_req
);

  logic w_found;

  // Rotating first-set search starting just after the last winner.
  always_comb begin
    grant   = '0;
    w_found = 1'b0;
    any_req = |req;
    for (int off = 1; off <= N_REQ; off++) begin
      if (!w_found && req[(int'(rr_ptr) + off) % N_REQ]) begin
        grant   = IW'((int'(rr_ptr) + off) % N_REQ);
        w_found = 1'b1;
      end else begin
        w_found = w_found;
      end
    end
  end

endmodule

// File: rtl/gcd_job_arbiter.sv
// gcd_job_arbiter: shares one serial-load subtract-loop GCD engine between
// N_REQ requesters. Round-robin picks a job, captures its operands, loads
// the engine (start+A, then B), waits for done and hands the result back.
// Zero operands bypass the engine since its loop would never terminate.
// Optional build macro: GCD_TIMEOUT_EN adds a WAIT watchdog that returns
// an error response after TIMEOUT_CYC cycles without eng_done.
module gcd_job_arbiter
  import gcd_pkg::*;
#(
  parameter int N_REQ       = 4,
  parameter int W           = GCD_W_DEF,
  parameter int TIMEOUT_CYC = GCD_TIMEOUT_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_REQ-1:0]   req,
  input  logic [N_REQ*W-1:0] op_a,
  input  logic [N_REQ*W-1:0] op_b,
  output logic [N_REQ-1:0]   ack,
  output logic [N_REQ-1:0]   rsp_valid,
  output logic [W-1:0]       rsp_data,
  output logic               rsp_err,
  input  logic [N_REQ-1:0]   rsp_ready,
  output logic               eng_start,
  output logic [W-1:0]       eng_data,
  output logic               eng_clr,
  input  logic               eng_done,
  input  logic [W-1:0]       eng_result,
  output logic               busy
);

  localparam int IW = $clog2(N_REQ);

  if (N_REQ < 2 || N_REQ > 8 || TIMEOUT_CYC < 1) begin : g_cfg_check
    $error("gcd_job_arbiter: N_REQ must be 2..8 and TIMEOUT_CYC >= 1");
  end

  gcd_state_e       r_state;
  gcd_state_e       w_next_state;
  logic [IW-1:0]    r_rr_ptr;
  logic [W-1:0]     r_a;
  logic [W-1:0]     r_b;
  logic [W-1:0]     r_res;
  logic [N_REQ-1:0] r_ack;
  logic             r_used;
  logic [IW-1:0]    w_grant;
  logic             w_any;
  logic [W-1:0]     w_op_a;
  logic [W-1:0]     w_op_b;
  logic             w_zero;
  logic [N_REQ-1:0] w_grant_oh;
  logic [N_REQ-1:0] w_owner_oh;
  logic             w_timeout;

  rr_picker #(
    .N_REQ (N_REQ),
    .IW    (IW)
  ) u_rr_picker (
    .req     (req),
    .rr_ptr  (r_rr_ptr),
    .grant   (w_grant),
    .any_req (w_any)
  );

  assign w_op_a     = op_a[int'(w_grant)*W +: W];
  assign w_op_b     = op_b[int'(w_grant)*W +: W];
  assign w_zero     = (w_op_a == {W{1'b0}}) || (w_op_b == {W{1'b0}});
  assign w_grant_oh = {{(N_REQ-1){1'b0}}, 1'b1} << w_grant;
  assign w_owner_oh = {{(N_REQ-1){1'b0}}, 1'b1} << r_rr_ptr;

`ifdef GCD_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC) + 1;

  logic [CNT_W-1:0] r_wait_cnt;
  logic             r_err;

  assign w_timeout = (r_wait_cnt == CNT_W'(TIMEOUT_CYC - 1));

  // WAIT-cycle watchdog counter, restarted on every entry into WAIT.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wait_cnt <= '0;
    end else if (r_state == LOAD_B) begin
      r_wait_cnt <= '0;
    end else if (r_state == WAIT) begin
      r_wait_cnt <= r_wait_cnt + CNT_W'(1);
    end else begin
      r_wait_cnt <= r_wait_cnt;
    end
  end

  // Error flag: cleared at capture, set when the watchdog fires.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_err <= 1'b0;
    end else if (r_state == IDLE && w_any) begin
      r_err <= 1'b0;
    end else if (r_state == WAIT && !eng_done && w_timeout) begin
      r_err <= 1'b1;
    end else begin
      r_err <= r_err;
    end
  end

  assign rsp_err = (r_state == RESP) && r_err;
`else
  assign w_timeout = 1'b0;
  assign rsp_err   = 1'b0;
`endif

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // FSM next-state logic.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE: begin
        if (w_any) begin
          w_next_state = w_zero ? RESP : LOAD_A;
        end else begin
          w_next_state = IDLE;
        end
      end
      LOAD_A: w_next_state = LOAD_B;
      LOAD_B: w_next_state = WAIT;
      WAIT: begin
        if (eng_done || w_timeout) begin
          w_next_state = RESP;
        end else begin
          w_next_state = WAIT;
        end
      end
      RESP: begin
        if (rsp_ready[r_rr_ptr]) begin
          w_next_state = r_used ? CLEAR : IDLE;
        end else begin
          w_next_state = RESP;
        end
      end
      CLEAR:   w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  // Job capture, grant pointer, ack pulse and result register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rr_ptr <= IW'(N_REQ - 1);
      r_a      <= '0;
      r_b      <= '0;
      r_res    <= '0;
      r_ack    <= '0;
      r_used   <= 1'b0;
    end else begin
      r_ack <= '0;
      case (r_state)
        IDLE: begin
          if (w_any) begin
            r_a      <= w_op_a;
            r_b      <= w_op_b;
            r_rr_ptr <= w_grant;
            r_ack    <= w_grant_oh;
            r_used   <= !w_zero;
            // Only meaningful on the bypass path; WAIT overwrites it.
            r_res    <= w_op_a | w_op_b;
          end else begin
            r_used <= r_used;
          end
        end
        WAIT: begin
          if (eng_done) begin
            r_res <= eng_result;
          end else if (w_timeout) begin
            r_res <= '0;
          end else begin
            r_res <= r_res;
          end
        end
        default: begin
          r_res <= r_res;
        end
      endcase
    end
  end

  // Output decode from registered state only.
  always_comb begin
    eng_start = (r_state == LOAD_A);
    eng_clr   = (r_state == CLEAR);
    busy      = (r_state != IDLE);
    rsp_valid = (r_state == RESP) ? w_owner_oh : {N_REQ{1'b0}};
    rsp_data  = (r_state == RESP) ? r_res : {W{1'b0}};
    case (r_state)
      LOAD_A:  eng_data = r_a;
      LOAD_B:  eng_data = r_b;
      default: eng_data = {W{1'b0}};
    endcase
  end

  assign ack = r_ack;

endmodule

// File: tb/tb_gcd_job_arbiter.sv
// Directed self-checking bench for gcd_job_arbiter with a behavioural
// subtract-loop engine stub. Timeout steps are built only with GCD_TIMEOUT_EN.
module tb_gcd_job_arbiter;

  localparam int N = 4;
  localparam int W = 16;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req;
  logic [N*W-1:0] op_a;
  logic [N*W-1:0] op_b;
  logic [N-1:0]   ack;
  logic [N-1:0]   rsp_valid;
  logic [W-1:0]   rsp_data;
  logic           rsp_err;
  logic [N-1:0]   rsp_ready;
  logic           eng_start;
  logic [W-1:0]   eng_data;
  logic           eng_clr;
  logic           eng_done;
  logic [W-1:0]   eng_result;
  logic           busy;

  int n_checks = 0;
  int n_errors = 0;
  int n_acks   = 0;
  int acks_at_start;

  // Engine stub state.
  logic [W-1:0] s_a = '0;
  logic [W-1:0] s_b = '0;
  logic         s_loadb = 1'b0;
  logic         s_run = 1'b0;
  logic         s_done = 1'b0;
  logic         stub_hold = 1'b0;

  always #5 clk = ~clk;

  gcd_job_arbiter #(.N_REQ(N), .W(W), .TIMEOUT_CYC(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .op_a       (op_a),
    .op_b       (op_b),
    .ack        (ack),
    .rsp_valid  (rsp_valid),
    .rsp_data   (rsp_data),
    .rsp_err    (rsp_err),
    .rsp_ready  (rsp_ready),
    .eng_start  (eng_start),
    .eng_data   (eng_data),
    .eng_clr    (eng_clr),
    .eng_done   (eng_done),
    .eng_result (eng_result),
    .busy       (busy)
  );

  // Serial-load subtract-loop engine stub; stub_hold freezes the loop.
  always @(posedge clk) begin
    if (eng_clr) begin
      s_run <= 1'b0; s_done <= 1'b0; s_loadb <= 1'b0;
    end else if (eng_start) begin
      s_a <= eng_data; s_loadb <= 1'b1; s_done <= 1'b0; s_run <= 1'b0;
    end else if (s_loadb) begin
      s_b <= eng_data; s_loadb <= 1'b0; s_run <= 1'b1;
    end else if (s_run && !stub_hold) begin
      if (s_a > s_b) s_a <= s_a - s_b;
      else if (s_b > s_a) s_b <= s_b - s_a;
      else begin s_done <= 1'b1; s_run <= 1'b0; end
    end
  end

  assign eng_done   = s_done;
  assign eng_result = s_a;

  // Count every ack bit seen, one sample per cycle.
  always @(negedge clk) begin
    if (!rst) n_acks <= n_acks + $countones(ack);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic set_ops(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
    op_a[i*W +: W] = a;
    op_b[i*W +: W] = b;
  endtask

  task automatic wait_ack(input string tag);
    int n = 0;
    while (ack == '0 && n < 40) begin tick(); n++; end
    chk({tag, "_ack_seen"}, 32'(ack != '0), 32'd1);
  endtask

  task automatic wait_rsp(input string tag);
    int n = 0;
    while (rsp_valid == '0 && n < 100) begin tick(); n++; end
    chk({tag, "_rsp_seen"}, 32'(rsp_valid != '0), 32'd1);
  endtask

  initial begin
    rst = 1'b1; req = '0; op_a = '0; op_b = '0; rsp_ready = '0;
    tick(); tick();
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_ack", 32'(ack), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_ctl", 32'({eng_start, eng_clr, rsp_err}), 32'd0);
    chk("rst_eng_data", 32'(eng_data), 32'd0);
    chk("rst_rsp_data", 32'(rsp_data), 32'd0);
    rst = 1'b0;
    tick();

    // Single job on requester 0: gcd(143,78)=13.
    set_ops(0, 16'd143, 16'd78); req = 4'b0001;
    tick();
    chk("single_ack", 32'(ack), 32'h1);
    chk("single_start", 32'(eng_start), 32'd1);
    chk("single_data_a", 32'(eng_data), 32'd143);
    chk("single_busy", 32'(busy), 32'd1);
    chk("single_no_rsp_yet", 32'(rsp_valid), 32'd0);
    req = '0;
    tick();
    chk("single_ack_drop", 32'(ack), 32'd0);
    chk("single_start_drop", 32'(eng_start), 32'd0);
    chk("single_data_b", 32'(eng_data), 32'd78);
    tick();
    chk("single_wait_data", 32'(eng_data), 32'd0);
    wait_rsp("single");
    chk("single_valid", 32'(rsp_valid), 32'h1);
    chk("single_result", 32'(rsp_data), 32'd13);
    chk("single_err", 32'(rsp_err), 32'd0);
    chk("single_no_clr", 32'(eng_clr), 32'd0);
    tick();
    chk("single_hold", 32'(rsp_valid), 32'h1);
    rsp_ready = 4'b0001; tick(); rsp_ready = '0;
    chk("single_valid_drop", 32'(rsp_valid), 32'd0);
    chk("single_data_zero", 32'(rsp_data), 32'd0);
    chk("single_clr", 32'(eng_clr), 32'd1);
    tick();
    chk("single_clr_drop", 32'(eng_clr), 32'd0);
    chk("single_idle", 32'(busy), 32'd0);

    // Backpressure on requester 3 while requester 1 queues up.
    set_ops(3, 16'd143, 16'd78); req = 4'b1000;
    wait_ack("bp");
    chk("bp_ack", 32'(ack), 32'h8);
    req = '0;
    wait_rsp("bp");
    set_ops(1, 16'd12, 16'd18); req = 4'b0010;
    for (int k = 0; k < 5; k++) begin
      rsp_ready = (k == 2) ? 4'b0010 : 4'b0000;
      chk("bp_valid_stable", 32'(rsp_valid), 32'h8);
      chk("bp_data_stable", 32'(rsp_data), 32'd13);
      chk("bp_no_ack", 32'(ack), 32'd0);
      tick();
    end
    chk("bp_other_ready_ignored", 32'(rsp_valid), 32'h8);
    rsp_ready = 4'b1000; tick(); rsp_ready = '0;
    chk("bp_clr", 32'(eng_clr), 32'd1);
    chk("bp_no_ack_clear", 32'(ack), 32'd0);
    tick();
    chk("bp_idle", 32'(busy), 32'd0);
    chk("bp_no_ack_idle", 32'(ack), 32'd0);
    tick();
    chk("bp_next_ack", 32'(ack), 32'h2);
    req = '0;
    wait_rsp("bp2");
    chk("bp2_valid", 32'(rsp_valid), 32'h2);
    chk("bp2_result", 32'(rsp_data), 32'd6);
    rsp_ready = 4'b0010; tick(); rsp_ready = '0;
    tick();
    chk("bp2_idle", 32'(busy), 32'd0);

    // Zero bypass: gcd(0,35)=35, gcd(0,0)=0, gcd(21,0)=21.
    set_ops(2, 16'd0, 16'd35); req = 4'b0100;
    tick();
    chk("zb_ack", 32'(ack), 32'h4);
    chk("zb_valid", 32'(rsp_valid), 32'h4);
    chk("zb_result", 32'(rsp_data), 32'd35);
    chk("zb_no_start", 32'(eng_start), 32'd0);
    req = '0; rsp_ready = 4'b0100; tick(); rsp_ready = '0;
    chk("zb_valid_drop", 32'(rsp_valid), 32'd0);
    chk("zb_no_clr", 32'(eng_clr), 32'd0);
    chk("zb_idle", 32'(busy), 32'd0);
    set_ops(2, 16'd0, 16'd0); req = 4'b0100;
    tick();
    chk("zb00_ack", 32'(ack), 32'h4);
    chk("zb00_valid", 32'(rsp_valid), 32'h4);
    chk("zb00_result", 32'(rsp_data), 32'd0);
    chk("zb00_no_start", 32'(eng_start), 32'd0);
    req = '0; rsp_ready = 4'b0100; tick(); rsp_ready = '0;
    set_ops(1, 16'd21, 16'd0); req = 4'b0010;
    tick();
    chk("zb_b0_valid", 32'(rsp_valid), 32'h2);
    chk("zb_b0_result", 32'(rsp_data), 32'd21);
    req = '0; rsp_ready = 4'b0010; tick(); rsp_ready = '0;
    chk("zb_b0_idle", 32'(busy), 32'd0);

    // Asynchronous reset while the engine is stuck in WAIT.
    stub_hold = 1'b1;
    set_ops(2, 16'd143, 16'd78); req = 4'b0100;
    wait_ack("rstw");
    req = '0;
    tick(); tick(); tick();
    chk("rstw_busy", 32'(busy), 32'd1);
    chk("rstw_no_rsp", 32'(rsp_valid), 32'd0);
    #2 rst = 1'b1;
    #1;
    chk("rstw_busy_now", 32'(busy), 32'd0);
    chk("rstw_outputs_now", 32'({ack, rsp_valid, eng_start, eng_clr, rsp_err}), 32'd0);
    chk("rstw_data_now", 32'({rsp_data, eng_data}), 32'd0);
    tick();
    rst = 1'b0; stub_hold = 1'b0;
    tick();

    // Fairness: all requesters held high, each job gcd(12,18)=6.
    for (int i = 0; i < N; i++) set_ops(i, 16'd12, 16'd18);
    acks_at_start = n_acks;
    req = 4'b1111;
    for (int j = 0; j < 5; j++) begin
      wait_ack("fair");
      chk("fair_grant", 32'(ack), 32'(4'b0001 << (j % 4)));
      wait_rsp("fair");
      chk("fair_owner", 32'(rsp_valid), 32'(4'b0001 << (j % 4)));
      chk("fair_result", 32'(rsp_data), 32'd6);
      rsp_ready = 4'b1111; tick(); rsp_ready = '0;
    end
    req = '0;
    tick(); tick(); tick();
    chk("fair_ack_count", 32'(n_acks - acks_at_start), 32'd5);
    chk("fair_idle", 32'(busy), 32'd0);

`ifdef GCD_TIMEOUT_EN
    // Watchdog: engine never finishes, error response after 8 WAIT cycles.
    stub_hold = 1'b1;
    set_ops(0, 16'd143, 16'd78); req = 4'b0001;
    wait_ack("to");
    req = '0;
    repeat (9) tick();
    chk("to_not_yet", 32'(rsp_valid), 32'd0);
    tick();
    chk("to_valid", 32'(rsp_valid), 32'h1);
    chk("to_err", 32'(rsp_err), 32'd1);
    chk("to_data", 32'(rsp_data), 32'd0);
    rsp_ready = 4'b0001; tick(); rsp_ready = '0;
    chk("to_clr", 32'(eng_clr), 32'd1);
    chk("to_err_drop", 32'(rsp_err), 32'd0);
    stub_hold = 1'b0;
    tick();
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
